fetch_pc_unit: RTL and testbench

- Instruction-fetch and next-PC stage of the MIPS core; sits directly upstream of the instruction decoder.
- Owns the PC register and the handshake with instruction memory.
- Holds the fetched instruction stable for the decoder, then uses the decoder's branch/jump/syscall flags and register operands to compute and commit the next PC.
- Halts the core on the exit syscall and keeps cycle and redirect counters.

---
 rtl/fetch_pc_unit.sv | 104 ++++++++++
 tb/tb_fetch_pc_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch / next-PC stage: owns the PC, fetches from instruction memory,
// presents the instruction to the decoder for one cycle, then commits the next PC.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TAKEN_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  input  logic               beq,
  input  logic               bne,
  input  logic               bgez,
  input  logic               j,
  input  logic               jal,
  input  logic               jr,
  input  logic               sys_call,
  input  logic [31:0]        rs_data,
  input  logic [31:0]        rt_data,
  input  logic               go,
  output logic               halt,
  output logic [31:0]        cycle_cnt,
  output logic [TAKEN_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

  localparam logic [31:0] SYS_EXIT = 32'd10;

  state_t      state, state_next;
  logic [31:0] pc_next;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        redirect;
  logic        exit_call;

  assign pc_plus4    = pc + 32'd4;
  assign imem_addr   = pc;
  // Request is gated by reset so the memory sees no request while the core is held in reset.
  assign imem_req    = (state == FETCH) && rst_n;
  assign instr_valid = (state == EXEC);
  assign halt        = (state == HALT);

  assign branch_target = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
  assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};

  // Next-PC selection; jal only matters to the register file, the PC treats it as j.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves a latch behind.
    pc_next   = pc_plus4;
    redirect  = 1'b0;
    exit_call = 1'b0;
    if (sys_call) begin
      exit_call = (rs_data == SYS_EXIT);
    end else if (jr) begin
      pc_next  = rs_data;
      redirect = 1'b1;
    end else if (j) begin
      pc_next  = jump_target;
      redirect = 1'b1;
    end else if ((beq && (rs_data == rt_data)) ||
                 (bne && (rs_data != rt_data)) ||
                 (bgez && !rs_data[31])) begin
      pc_next  = branch_target;
      redirect = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      FETCH:   if (imem_ack) state_next = EXEC;
      EXEC:    state_next = exit_call ? HALT : FETCH;
      HALT:    if (go) state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      instr     <= '0;
      cycle_cnt <= '0;
      taken_cnt <= '0;
    end else begin
      state <= state_next;
      if (state != HALT) cycle_cnt <= cycle_cnt + 32'd1;
      if ((state == FETCH) && imem_ack) instr <= imem_rdata;
      if (state == EXEC) begin
        pc <= pc_next;
        if (redirect && !(&taken_cnt)) taken_cnt <= taken_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus randomized traffic,
// compared every cycle against an instruction-level reference model.
module tb_fetch_pc_unit;

  localparam int          TW   = 4;
  localparam logic [31:0] TMAX = (32'd1 << TW) - 32'd1;

  // Flag vector layout: {beq, bne, bgez, j, jal, jr, sys_call}
  localparam logic [6:0] F_NONE = 7'b0000000;
  localparam logic [6:0] F_BEQ  = 7'b1000000;
  localparam logic [6:0] F_BGEZ = 7'b0010000;
  localparam logic [6:0] F_J    = 7'b0001000;
  localparam logic [6:0] F_JAL  = 7'b0000100;
  localparam logic [6:0] F_JR   = 7'b0000010;
  localparam logic [6:0] F_SYS  = 7'b0000001;

  localparam int P_FETCH = 0, P_EXEC = 1, P_HALT = 2;

  logic          clk, rst_n;
  logic          imem_req, imem_ack;
  logic [31:0]   imem_addr, imem_rdata;
  logic [31:0]   instr, pc, pc_plus4, rs_data, rt_data, cycle_cnt;
  logic          instr_valid, go, halt;
  logic [6:0]    flags;
  logic [TW-1:0] taken_cnt;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  int          m_phase;
  logic [31:0] m_pc, m_instr, m_cyc, m_taken;

  fetch_pc_unit #(.RESET_PC(32'h0), .TAKEN_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .beq(flags[6]), .bne(flags[5]), .bgez(flags[4]), .j(flags[3]), .jal(flags[2]),
    .jr(flags[1]), .sys_call(flags[0]),
    .rs_data(rs_data), .rt_data(rt_data), .go(go), .halt(halt),
    .cycle_cnt(cycle_cnt), .taken_cnt(taken_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // {taken, next_pc} for the instruction in EXEC, straight from the ISA rules.
  function automatic logic [32:0] resolve(input logic [31:0] ins, input logic [31:0] cur_pc,
                                          input logic [6:0] fl, input logic [31:0] rs,
                                          input logic [31:0] rt);
    logic [31:0] p4, bt;
    p4 = cur_pc + 32'd4;
    bt = p4 + ({{16{ins[15]}}, ins[15:0]} << 2);
    if (fl[0])                return {1'b0, p4};
    if (fl[1])                return {1'b1, rs};
    if (fl[3])                return {1'b1, p4[31:28], ins[25:0], 2'b00};
    if (fl[6] && rs == rt)    return {1'b1, bt};
    if (fl[5] && rs != rt)    return {1'b1, bt};
    if (fl[4] && !rs[31])     return {1'b1, bt};
    return {1'b0, p4};
  endfunction

  task automatic model_reset();
    m_phase = P_FETCH;
    m_pc    = 32'h0;
    m_instr = 32'h0;
    m_cyc   = 32'h0;
    m_taken = 32'h0;
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_step();
    logic [32:0] r;
    if (m_phase != P_HALT) m_cyc = m_cyc + 32'd1;
    case (m_phase)
      P_FETCH: if (imem_ack) begin
        m_instr = imem_rdata;
        m_phase = P_EXEC;
      end
      P_EXEC: begin
        r       = resolve(m_instr, m_pc, flags, rs_data, rt_data);
        m_pc    = r[31:0];
        m_phase = (flags[0] && rs_data == 32'd10) ? P_HALT : P_FETCH;
        if (r[32] && m_taken != TMAX) m_taken = m_taken + 32'd1;
      end
      default: if (go) m_phase = P_FETCH;
    endcase
  endtask

  task automatic compare_all();
    logic req_exp;
    req_exp = (m_phase == P_FETCH) && rst_n;
    check("pc",          pc,                  m_pc);
    check("pc_plus4",    pc_plus4,            m_pc + 32'd4);
    check("instr",       instr,               m_instr);
    check("instr_valid", 32'(instr_valid),    32'(m_phase == P_EXEC));
    check("halt",        32'(halt),           32'(m_phase == P_HALT));
    check("imem_req",    32'(imem_req),       32'(req_exp));
    if (req_exp) check("imem_addr", imem_addr, m_pc);
    check("cycle_cnt",   cycle_cnt,           m_cyc);
    check("taken_cnt",   32'(taken_cnt),      m_taken);
  endtask

  task automatic tick(input logic ack, input logic [31:0] rdata, input logic [6:0] fl,
                      input logic [31:0] rs, input logic [31:0] rt, input logic g);
    imem_ack   = ack;
    imem_rdata = rdata;
    flags      = fl;
    rs_data    = rs;
    rt_data    = rt;
    go         = g;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Zero-wait fetch followed by one EXEC cycle; a stray ack in EXEC must be ignored.
  task automatic run_instr(input logic [31:0] rdata, input logic [6:0] fl,
                           input logic [31:0] rs, input logic [31:0] rt);
    tick(1'b1, rdata, F_NONE, 32'h0, 32'h0, 1'b0);
    tick(1'b1, 32'hDEAD_BEEF, fl, rs, rt, 1'b0);
  endtask

  task automatic goto_pc(input logic [31:0] target);
    run_instr(32'h0000_0008, F_JR, target, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
    #1;
    compare_all();
  endtask

  initial begin
    logic [6:0]  fl;
    logic [31:0] rs, rt;
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; flags = '0;
    rs_data = '0; rt_data = '0; go = 1'b0;
    model_reset();
    #2;
    do_reset();
    check("lit_reset_pc", pc, 32'h0);

    // Sequential NOP stream, zero-wait memory.
    for (int i = 0; i < 8; i++) tick(1'b1, 32'h0, F_NONE, $urandom, $urandom, 1'b0);
    check("lit_cycle_cnt_8", cycle_cnt, 32'd8);
    check("lit_pc_after_4", pc, 32'h10);

    // beq taken backwards: pc 0x20, imm -2 -> 0x1C.
    goto_pc(32'h20);
    run_instr({6'h04, 5'd1, 5'd2, 16'hFFFE}, F_BEQ, 32'd5, 32'd5);
    check("lit_beq_pc", pc, 32'h1C);
    check("lit_beq_taken", 32'(taken_cnt), 32'd2);

    // bgez on a negative operand falls through.
    goto_pc(32'h40);
    run_instr({6'h01, 5'd1, 5'd1, 16'h0010}, F_BGEZ, 32'h8000_0000, 32'h0);
    check("lit_bgez_pc", pc, 32'h44);
    check("lit_bgez_taken", 32'(taken_cnt), 32'd3);

    // jal, then jr with j also asserted (jr wins).
    goto_pc(32'h0040_0010);
    tick(1'b1, {6'h03, 26'h000_0100}, F_NONE, 32'h0, 32'h0, 1'b0);
    check("lit_jal_link", pc_plus4, 32'h0040_0014);
    tick(1'b0, 32'h0, F_J | F_JAL, 32'h0, 32'h0, 1'b0);
    check("lit_jal_pc", pc, 32'h0000_0400);
    run_instr({6'h02, 26'h3FF_FFFF}, F_J | F_JR, 32'h0040_0014, 32'h0);
    check("lit_jr_pc", pc, 32'h0040_0014);

    // Exit syscall halts; acks ignored, counter frozen; go resumes at 0x54.
    goto_pc(32'h50);
    run_instr(32'h0000_000C, F_SYS, 32'd10, 32'h0);
    check("lit_halt", 32'(halt), 32'd1);
    check("lit_halt_pc", pc, 32'h54);
    for (int i = 0; i < 4; i++) tick(1'b1, $urandom, F_NONE, 32'h0, 32'h0, 1'b0);
    tick(1'b0, 32'h0, F_NONE, 32'h0, 32'h0, 1'b1);
    check("lit_resume_req", 32'(imem_req), 32'd1);
    check("lit_resume_addr", imem_addr, 32'h54);
    run_instr(32'h0000_000C, F_SYS, 32'd1, 32'h0);
    check("lit_sys_other_pc", pc, 32'h58);

    // Wait states, then reset in the middle of the wait.
    goto_pc(32'h100);
    for (int i = 0; i < 3; i++) tick(1'b0, $urandom, F_NONE, 32'h0, 32'h0, 1'b0);
    check("lit_wait_addr", imem_addr, 32'h100);
    check("lit_wait_instr", instr, 32'h0000_0008);
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    do_reset();
    check("lit_rst_pc", pc, 32'h0);
    check("lit_rst_instr", instr, 32'h0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 4000; n++) begin
      fl = '0;
      for (int b = 1; b < 7; b++) fl[b] = ($urandom_range(0, 5) == 0);
      fl[0] = ($urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 3) == 0) ? 32'd10 : $urandom;
      if ($urandom_range(0, 2) == 0) rs[31] = 1'b0;
      rt = $urandom_range(0, 1) ? rs : $urandom;
      tick($urandom_range(0, 2) != 0, $urandom, fl, rs, rt, $urandom_range(0, 2) == 0);
      if (n % 997 == 500) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
